matrix_result_drain: RTL and testbench
======================================

Name: matrix_result_drain

Overview:
- Read-side counterpart to the 3x3 systolic MAC array feeder.
- Snapshots the nine MAC accumulators when the array signals completion, then streams C[r][c] out serially in row-major order over a valid/ready handshake.
- After the last beat is accepted, pulses a clear so the array can start the next product.
- Sits between the MAC array outputs and the downstream consumer (UART/display/result FIFO).

Parameters:
- ACC_W, 16, width of each MAC accumulator input.
- OUT_W, 8, width of the streamed result word; must satisfy OUT_W <= ACC_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- array_done  input  1  one-cycle pulse: all nine accumulators hold final values.
- acc_flat  input  9*ACC_W  accumulators packed, C00 in [ACC_W-1:0], then C01, C02, C10 … C22 in the top slice.
- out_ready  input  1  consumer accepts the current beat.
- out_valid  output  1  out_data holds a valid element.
- out_data  output  OUT_W  current element value.
- out_row  output  2  row index of the current element (0..2).
- out_col  output  2  column index of the current element (0..2).
- out_last  output  1  high with element C22.
- busy  output  1  high in STREAM or CLEAR.
- acc_clear  output  1  one-cycle pulse to zero the MAC array.
- overrun  output  1  sticky flag: array_done arrived while busy.

Behaviour:
- Reset (asynchronous, any state): all outputs 0; state IDLE; index 0; snapshot registers 0; overrun cleared.
- States: IDLE, STREAM, CLEAR.
- IDLE:
  - array_done=1 latches all nine ACC_W slices into the snapshot, sets index=0 and moves to STREAM.
  - out_valid rises on the next cycle (latency 1 from array_done to first beat C00).
- STREAM:
  - out_valid=1.
  - out_data = snapshot[index] reduced to OUT_W.
  - out_row = index/3, out_col = index%3.
  - out_last = (index==8).
- Handshake:
  - A beat transfers on a rising edge with out_valid & out_ready.
  - index increments by 1 per transfer.
  - While out_ready=0, out_data, out_row, out_col and out_last hold stable.
  - out_ready is combinationally allowed to stay high, giving one beat per cycle: 9 beats in 9 cycles minimum.
- Last beat: a transfer at index 8 moves to CLEAR and drops out_valid the same edge.
- CLEAR:
  - acc_clear=1 for exactly one cycle, then IDLE.
  - busy drops on entering IDLE.
- Overrun:
  - array_done in STREAM or CLEAR is ignored; the snapshot is unchanged.
  - overrun is set and stays set until reset.
  - array_done in the same cycle CLEAR exits is also an overrun.
  - Capture resumes only from IDLE.
- Width reduction (macro absent): out_data = low OUT_W bits of the snapshot (truncation).
- Snapshot isolation: acc_flat changes during STREAM do not affect out_data.
- Reset mid-stream: the stream is aborted with no further beats, and acc_clear is not pulsed.

Optional Feature:
- Macro: MATRIX_DRAIN_SAT_EN.
- Defined:
  - out_data = min(snapshot, 2^OUT_W-1) (unsigned saturation).
  - Adds output sat_flag (1 bit), high with any beat whose value was clamped.
  - sat_flag follows the same stability rule as out_data.
- Undefined:
  - Truncation only.
  - The sat_flag port does not exist.

Decomposition:
- Package matrix_pkg:
  - constant MAT_N=3, constant MAT_ELEMS=9, IDX_W=4.
  - enum drain_state_t {IDLE, STREAM, CLEAR}.
  - shared with the feeder/array.
- Sub-module drain_reduce: combinational ACC_W→OUT_W truncate/saturate, with a sat output under the macro.
- The FSM, index counter and snapshot stay in matrix_result_drain.

Test Plan:
- Basic stream:
  - Stimulus: acc values C00..C22 = 1..9, pulse array_done, out_ready held 1.
  - Required: beats 1..9 on 9 consecutive cycles starting 1 cycle after done; row/col 0,0 … 2,2; out_last only on 9; acc_clear pulses one cycle after the last beat; busy low afterwards.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1… with values 1..9.
  - Required: no beat lost or duplicated; data stable through every ready=0 cycle; exactly 9 transfers.
- Snapshot isolation:
  - Stimulus: change acc_flat to all 0xFFFF two cycles after done.
  - Required: streamed values stay 1..9.
- Overrun:
  - Stimulus: second array_done during beat 4.
  - Required: overrun=1 and stays 1; stream continues with the original data; no restart.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges after beat 5.
  - Required: out_valid, busy and acc_clear go 0 immediately; the next array_done starts fresh from C00.
- Width reduction:
  - Stimulus: C11=0x01A5, OUT_W=8.
  - Required: out_data=0xA5 without MATRIX_DRAIN_SAT_EN; 0xFF with sat_flag=1 when the macro is defined.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 systolic MAC array, its feeder and the result drain.
package matrix_pkg;

  localparam int MAT_N     = 3;
  localparam int MAT_ELEMS = 9;
  localparam int IDX_W     = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CLEAR  = 2'd2
  } drain_state_t;

  // Row-major element index to row number.
  function automatic logic [1:0] idx_row(input logic [IDX_W-1:0] idx);
    logic [1:0] r;
    case (idx)
      4'd0, 4'd1, 4'd2: r = 2'd0;
      4'd3, 4'd4, 4'd5: r = 2'd1;
      4'd6, 4'd7, 4'd8: r = 2'd2;
      default:          r = 2'd0;
    endcase
    return r;
  endfunction

  // Row-major element index to column number.
  function automatic logic [1:0] idx_col(input logic [IDX_W-1:0] idx);
    logic [1:0] c;
    case (idx)
      4'd0, 4'd3, 4'd6: c = 2'd0;
      4'd1, 4'd4, 4'd7: c = 2'd1;
      4'd2, 4'd5, 4'd8: c = 2'd2;
      default:          c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/drain_reduce.sv
// Narrows one ACC_W accumulator value to OUT_W bits: truncation by default,
// unsigned saturation with a sat indication when MATRIX_DRAIN_SAT_EN is defined.
module drain_reduce #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] value,
  output logic [OUT_W-1:0] data
`ifdef MATRIX_DRAIN_SAT_EN
  ,
  output logic             sat
`endif
);

  logic over_s;

  generate
    if (OUT_W < ACC_W) begin : g_narrow
      assign over_s = |value[ACC_W-1:OUT_W];
    end else begin : g_equal
      assign over_s = 1'b0;
    end
  endgenerate

`ifdef MATRIX_DRAIN_SAT_EN
  assign data = over_s ? {OUT_W{1'b1}} : value[OUT_W-1:0];
  assign sat  = over_s;
`else
  logic unused_over_s;
  assign unused_over_s = over_s;
  assign data          = value[OUT_W-1:0];
`endif

endmodule

// File: rtl/matrix_result_drain.sv
// Snapshots the 3x3 accumulator bank on array_done and streams it row-major over
// valid/ready, then pulses acc_clear. MATRIX_DRAIN_SAT_EN selects saturating output.
module matrix_result_drain
  import matrix_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       array_done,
  input  logic [MAT_ELEMS*ACC_W-1:0] acc_flat,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic [1:0]                 out_row,
  output logic [1:0]                 out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       acc_clear,
  output logic                       overrun
`ifdef MATRIX_DRAIN_SAT_EN
  ,
  output logic                       sat_flag
`endif
);

  drain_state_t     state_r;
  drain_state_t     state_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_s;
  logic             capture_s;
  logic [ACC_W-1:0] snap_r [MAT_ELEMS];
  logic [ACC_W-1:0] sel_s;
  logic [OUT_W-1:0] red_data_s;
  logic             red_sat_s;
  logic             streaming_s;

  // Next state and element index; a beat transfers whenever STREAM sees out_ready.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (array_done) begin
          state_s   = STREAM;
          idx_s     = {IDX_W{1'b0}};
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = CLEAR;
            idx_s   = {IDX_W{1'b0}};
          end else begin
            idx_s = idx_r + 4'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      CLEAR: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Element that will be presented next cycle; on capture it comes straight from C00.
  always_comb begin
    sel_s = {ACC_W{1'b0}};
    if (capture_s) begin
      sel_s = acc_flat[ACC_W-1:0];
    end else begin
      for (int k = 0; k < MAT_ELEMS; k++) begin
        sel_s = (idx_s == IDX_W'(k)) ? snap_r[k] : sel_s;
      end
    end
  end

  assign streaming_s = (state_s == STREAM);

  drain_reduce #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_reduce (
    .value (sel_s),
    .data  (red_data_s)
`ifdef MATRIX_DRAIN_SAT_EN
    ,
    .sat   (red_sat_s)
`endif
  );

`ifndef MATRIX_DRAIN_SAT_EN
  assign red_sat_s = 1'b0;
`endif

  // State, index and snapshot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= {IDX_W{1'b0}};
      for (int k = 0; k < MAT_ELEMS; k++) begin
        snap_r[k] <= {ACC_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (capture_s) begin
        for (int k = 0; k < MAT_ELEMS; k++) begin
          snap_r[k] <= acc_flat[k*ACC_W +: ACC_W];
        end
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_row   <= 2'd0;
      out_col   <= 2'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      acc_clear <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= streaming_s;
      out_data  <= streaming_s ? red_data_s : {OUT_W{1'b0}};
      out_row   <= streaming_s ? idx_row(idx_s) : 2'd0;
      out_col   <= streaming_s ? idx_col(idx_s) : 2'd0;
      out_last  <= streaming_s && (idx_s == LAST_IDX);
      busy      <= (state_s != IDLE);
      acc_clear <= (state_s == CLEAR);
      overrun   <= overrun | (array_done && (state_r != IDLE));
    end
  end

`ifdef MATRIX_DRAIN_SAT_EN
  // Clamp indication travels with the beat it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= streaming_s && red_sat_s;
    end
  end
`else
  logic unused_sat_s;
  assign unused_sat_s = red_sat_s;
`endif

endmodule

// File: tb/tb_matrix_result_drain.sv
// Directed bench for matrix_result_drain with a queue-based model of the expected beat stream.
module tb_matrix_result_drain;

  localparam int ACC_W = 16;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             array_done = 1'b0;
  logic [9*ACC_W-1:0] acc_flat = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_last;
  logic             busy;
  logic             acc_clear;
  logic             overrun;
`ifdef MATRIX_DRAIN_SAT_EN
  logic             sat_flag;
`endif

  matrix_result_drain #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .array_done (array_done),
    .acc_flat   (acc_flat),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .acc_clear  (acc_clear),
    .overrun    (overrun)
`ifdef MATRIX_DRAIN_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] row;
    logic [1:0] col;
    logic       last;
    logic       sat;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] log_q[$];
  logic       clear_due = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       active_m;
  logic [7:0] seen_data = 8'd0;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic beat_t make_beat(int k, logic [15:0] v);
    beat_t b;
    b.row  = 2'(k / 3);
    b.col  = 2'(k % 3);
    b.last = (k == 8);
`ifdef MATRIX_DRAIN_SAT_EN
    if (v > 16'd255) begin
      b.data = 8'hFF;
      b.sat  = 1'b1;
    end else begin
      b.data = v[7:0];
      b.sat  = 1'b0;
    end
`else
    b.data = v[7:0];
    b.sat  = 1'b0;
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a capture queues nine expected beats; each accepted beat pops one; clear follows the last.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      clear_due = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      active_m = (exp_q.size() != 0) || clear_due;
      if (exp_q.size() != 0) begin
        if (out_ready) begin
          log_q.push_back(seen_data);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) clear_due = 1'b1;
        end
      end else if (clear_due) begin
        clear_due = 1'b0;
      end
      if (array_done) begin
        if (active_m) exp_ovr = 1'b1;
        else for (int k = 0; k < 9; k++) exp_q.push_back(make_beat(k, acc_flat[k*16 +: 16]));
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_clear", 32'(acc_clear), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
    end else begin
      seen_data = out_data;
      chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0 || clear_due));
      chk("acc_clear", 32'(acc_clear), 32'(clear_due));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      if (exp_q.size() != 0) begin
        chk("data", 32'(out_data), 32'(exp_q[0].data));
        chk("row", 32'(out_row), 32'(exp_q[0].row));
        chk("col", 32'(out_col), 32'(exp_q[0].col));
        chk("last", 32'(out_last), 32'(exp_q[0].last));
`ifdef MATRIX_DRAIN_SAT_EN
        chk("sat_flag", 32'(sat_flag), 32'(exp_q[0].sat));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vals();
    for (int k = 0; k < 9; k++) acc_flat[k*16 +: 16] = 16'(k + 1);
  endtask

  task automatic pulse_done();
    array_done = 1'b1;
    tick();
    array_done = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || clear_due) && (n < budget)) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'((exp_q.size() != 0) || clear_due), 32'd0);
  endtask

  task automatic wait_beats(input int cnt, input int budget);
    int n;
    n = 0;
    while ((log_q.size() < cnt) && (n < budget)) begin
      tick();
      n++;
    end
    chk("beat_timeout", 32'(log_q.size() >= cnt), 32'd1);
  endtask

  logic pat [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Basic stream at full rate.
    load_vals();
    out_ready = 1'b1;
    log_q.delete();
    pulse_done();
    wait_idle(30);
    chk("basic_count", 32'(log_q.size()), 32'd9);
    chk("basic_first", 32'(log_q[0]), 32'd1);
    chk("basic_ninth", 32'(log_q[8]), 32'd9);
    chk("basic_busy_low", 32'(busy), 32'd0);

    // Backpressure with ready 1,0,0 repeating.
    log_q.delete();
    array_done = 1'b1;
    for (int i = 0; i < 60; i++) begin
      out_ready = pat[i % 3];
      tick();
      array_done = 1'b0;
      if ((i > 0) && (exp_q.size() == 0) && !clear_due) break;
    end
    out_ready = 1'b1;
    wait_idle(10);
    chk("bp_count", 32'(log_q.size()), 32'd9);
    chk("bp_fifth", 32'(log_q[4]), 32'd5);

    // Snapshot isolation.
    log_q.delete();
    pulse_done();
    tick();
    acc_flat = {9{16'hFFFF}};
    wait_idle(30);
    chk("iso_first", 32'(log_q[0]), 32'd1);
    chk("iso_ninth", 32'(log_q[8]), 32'd9);
    load_vals();

    // Overrun during the stream.
    log_q.delete();
    pulse_done();
    wait_beats(4, 30);
    pulse_done();
    wait_idle(30);
    repeat (3) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_count", 32'(log_q.size()), 32'd9);
    chk("ovr_fifth", 32'(log_q[4]), 32'd5);
    chk("ovr_no_restart", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream.
    log_q.delete();
    pulse_done();
    wait_beats(5, 30);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clear", 32'(acc_clear), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    log_q.delete();
    pulse_done();
    wait_idle(30);
    chk("arst_restart_first", 32'(log_q[0]), 32'd1);
    chk("arst_restart_count", 32'(log_q.size()), 32'd9);

    // Width reduction on C11.
    acc_flat[4*16 +: 16] = 16'h01A5;
    log_q.delete();
    pulse_done();
    wait_idle(30);
`ifdef MATRIX_DRAIN_SAT_EN
    chk("width_c11", 32'(log_q[4]), 32'h0000_00FF);
`else
    chk("width_c11", 32'(log_q[4]), 32'h0000_00A5);
`endif
    chk("width_c12", 32'(log_q[5]), 32'd6);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
